// File: rtl/ysyx_ifq.sv
// Instruction fetch queue between IFU and IDU: registered FIFO of {inst, pc, speculation}
// beats. A flush or reset drops every entry. Status flags come from registered state only.
module ysyx_ifq #(
    parameter int BIT_W = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             prev_valid,
    output logic             ready_o,
    input  logic [31:0]      inst,
    input  logic [BIT_W-1:0] pc,
    input  logic             speculation,
    output logic             valid_o,
    input  logic             next_ready,
    output logic [31:0]      inst_o,
    output logic [BIT_W-1:0] pc_o,
    output logic             speculation_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      inst_mem [DEPTH];
    logic [BIT_W-1:0] pc_mem   [DEPTH];
    logic             spec_mem [DEPTH];

    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] count;
    logic             enq;
    logic             deq;

    // ready_o ignores next_ready: a full queue never accepts, even while draining
    always_comb begin
        valid_o = (count != '0);
        ready_o = (count != CNT_W'(DEPTH));
        enq     = prev_valid & ready_o & ~flush;
        deq     = valid_o & next_ready & ~flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + PTR_W'(1);
            if (deq) rptr <= rptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[wptr] <= inst;
            pc_mem[wptr]   <= pc;
            spec_mem[wptr] <= speculation;
        end
    end

    always_comb begin
        inst_o        = valid_o ? inst_mem[rptr] : '0;
        pc_o          = valid_o ? pc_mem[rptr]   : '0;
        speculation_o = valid_o ? spec_mem[rptr] : 1'b0;
        count_o       = count;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(enq && (count == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(deq && (count == '0)));
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ysyx_ifq.sv
// Bench for ysyx_ifq: directed stimulus plus a scoreboard monitor that predicts
// occupancy and pops expected beats whenever the IDU handshake completes.
module tb_ysyx_ifq;

    localparam int BIT_W = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]      inst;
        logic [BIT_W-1:0] pc;
        logic             spec;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             prev_valid = 1'b0;
    logic             ready_o;
    logic [31:0]      inst = '0;
    logic [BIT_W-1:0] pc = '0;
    logic             speculation = 1'b0;
    logic             valid_o;
    logic             next_ready = 1'b0;
    logic [31:0]      inst_o;
    logic [BIT_W-1:0] pc_o;
    logic             speculation_o;
    logic [CNT_W-1:0] count_o;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mon_en = 1'b0;
    beat_t sb[$];
    int    mcount = 0;

    ysyx_ifq #(.BIT_W(BIT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .prev_valid(prev_valid), .ready_o(ready_o),
        .inst(inst), .pc(pc), .speculation(speculation), .valid_o(valid_o),
        .next_ready(next_ready), .inst_o(inst_o), .pc_o(pc_o),
        .speculation_o(speculation_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit pv, input logic [31:0] i, input logic [31:0] p,
                         input bit s, input bit nr, input bit fl);
        prev_valid  = pv;
        inst        = i;
        pc          = p;
        speculation = s;
        next_ready  = nr;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && count_o != '0; k++)
            cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check(name, 32'(count_o), 32'd0);
        idle();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, 32'(count_o), 32'd0);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_ready"}, 32'(ready_o), 32'd1);
        check({tag, "_inst"},  inst_o, 32'd0);
        check({tag, "_pc"},    pc_o, 32'd0);
        check({tag, "_spec"},  32'(speculation_o), 32'd0);
    endtask

    // Monitor: compare flags against the predicted occupancy, pop on each IDU handshake
    always @(negedge clk) begin
        if (mon_en) begin
            bit    enq_m;
            bit    deq_m;
            beat_t exp_b;
            check("mon_count", 32'(count_o), 32'(mcount));
            check("mon_valid", 32'(valid_o), 32'(mcount != 0));
            check("mon_ready", 32'(ready_o), 32'(mcount != DEPTH));
            if (mcount == 0)
                check("mon_empty_data", inst_o | pc_o | 32'(speculation_o), 32'd0);
            enq_m = prev_valid && (mcount != DEPTH) && !flush;
            deq_m = (mcount != 0) && next_ready && !flush;
            if (rst || flush) begin
                sb.delete();
                mcount = 0;
            end else begin
                if (deq_m) begin
                    if (sb.size() == 0) begin
                        check("mon_sb_underrun", 32'd1, 32'd0);
                    end else begin
                        exp_b = sb.pop_front();
                        check("mon_inst", inst_o, exp_b.inst);
                        check("mon_pc",   pc_o,   exp_b.pc);
                        check("mon_spec", 32'(speculation_o), 32'(exp_b.spec));
                    end
                end
                if (enq_m) sb.push_back('{inst, pc, speculation});
                mcount = mcount + int'(enq_m) - int'(deq_m);
            end
        end
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        check_reset_vals("reset");

        // Fill four entries while the IDU stalls, then offer a fifth beat
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h0000_0013 | (32'(i) << 20), 32'h8000_0000 + 32'(4 * i),
                  i[0], 1'b0, 1'b0);
        check("fill_ready", 32'(ready_o), 32'd0);
        check("fill_count", 32'(count_o), 32'd4);
        check("fill_valid", 32'(valid_o), 32'd1);
        check("fill_pc",    pc_o, 32'h8000_0000);
        cycle(1'b1, 32'h0000_0093, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
        check("full_hold_count", 32'(count_o), 32'd4);

        // Full plus dequeue: the offered beat is refused
        cycle(1'b1, 32'h0000_0113, 32'h8000_0014, 1'b0, 1'b1, 1'b0);
        check("fulldeq_count", 32'(count_o), 32'd3);
        check("fulldeq_ready", 32'(ready_o), 32'd1);
        check("fulldeq_pc",    pc_o, 32'h8000_0004);

        // Flush with both handshakes offered: nothing enqueued or consumed
        cycle(1'b1, 32'h0000_0193, 32'h8000_0018, 1'b0, 1'b1, 1'b1);
        check("flush_count", 32'(count_o), 32'd0);
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_inst",  inst_o, 32'd0);
        cycle(1'b1, 32'h0010_0073, 32'h8000_0100, 1'b0, 1'b0, 1'b0);
        check("postflush_valid", 32'(valid_o), 32'd1);
        check("postflush_inst",  inst_o, 32'h0010_0073);
        check("postflush_pc",    pc_o, 32'h8000_0100);
        drain("postflush_drain");

        // Streaming: one beat in and one out per cycle after the first
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h0000_1013 + 32'(i), 32'h8000_1000 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
            check("stream_count", 32'(count_o), 32'd1);
        end
        drain("stream_drain");

        // Wrap: nine pushes with stalls and irregular pops, speculation 1,0,1,...
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 32'h0000_2013 + 32'(i), 32'h8000_2000 + 32'(4 * i),
                  (i % 2) == 0, (i % 3) != 0, 1'b0);
            if (i[0]) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        drain("wrap_drain");

        // Reset with two entries buffered and both handshakes offered
        cycle(1'b1, 32'h0000_3013, 32'h8000_3000, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_3113, 32'h8000_3004, 1'b0, 1'b0, 1'b0);
        check("prerst_count", 32'(count_o), 32'd2);
        rst = 1'b1;
        cycle(1'b1, 32'h0000_3213, 32'h8000_3008, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check_reset_vals("midrst");
        cycle(1'b1, 32'h0000_3313, 32'h8000_300c, 1'b1, 1'b0, 1'b0);
        check("postrst_count", 32'(count_o), 32'd1);
        check("postrst_pc",    pc_o, 32'h8000_300c);
        check("postrst_spec",  32'(speculation_o), 32'd1);
        drain("postrst_drain");

        idle();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
